// File: rtl/vec_data_mem_strided.sv
// Parametrised vector data memory with per-lane masking and strided/broadcast
// element addressing; one-cycle registered loads and per-lane range flags.
module vec_data_mem_strided #(
   parameter int NLANES = 6,
   parameter int LANE_W = 8,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req,
   input  logic                             WE,
   input  logic [ADDR_W-1:0]                A,
   input  logic [7:0]                       STRIDE,
   input  logic [NLANES-1:0]                WMASK,
   input  logic [NLANES-1:0][LANE_W-1:0]    WD,
   output logic [NLANES-1:0][LANE_W-1:0]    RD,
   output logic                             rvalid,
   output logic                             err,
   output logic [NLANES-1:0]                err_mask
);

   // Wide enough that A + (NLANES-1)*255 never wraps, so range checks are exact.
   localparam int EXT_W = ADDR_W + 8 + $clog2(NLANES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [LANE_W-1:0] mem [DEPTH];

   logic [EXT_W-1:0] laneAddr [NLANES];
   logic [IDX_W-1:0] laneIdx  [NLANES];
   logic [NLANES-1:0] inRange;

   logic [NLANES-1:0][LANE_W-1:0] rdData_q, rdData_d;
   logic                          rvalid_q, rvalid_d;
   logic                          err_q, err_d;
   logic [NLANES-1:0]             errMask_q, errMask_d;

   always_comb begin
      for (int i = 0; i < NLANES; i++) begin
         laneAddr[i] = EXT_W'(A) + EXT_W'(i) * EXT_W'(STRIDE);
         inRange[i]  = laneAddr[i] < EXT_W'(DEPTH);
         laneIdx[i]  = laneAddr[i][IDX_W-1:0];
      end
   end

   // Lanes are written in ascending order so the highest lane wins on a collision.
   always_ff @(posedge clk) begin
      if (!rst && req && WE) begin
         for (int i = 0; i < NLANES; i++) begin
            if (WMASK[i] && inRange[i]) begin
               mem[laneIdx[i]] <= WD[i];
            end
         end
      end
   end

   always_comb begin
      rdData_d  = rdData_q;
      rvalid_d  = 1'b0;
      errMask_d = '0;
      if (req) begin
         errMask_d = ~inRange;
         if (!WE) begin
            rvalid_d = 1'b1;
            for (int i = 0; i < NLANES; i++) begin
               rdData_d[i] = inRange[i] ? mem[laneIdx[i]] : '0;
            end
         end
      end
      err_d = |errMask_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdData_q  <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         errMask_q <= '0;
      end else begin
         rdData_q  <= rdData_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         errMask_q <= errMask_d;
      end
   end

   assign RD       = rdData_q;
   assign rvalid   = rvalid_q;
   assign err      = err_q;
   assign err_mask = errMask_q;

endmodule
